bin_decode_scheduler: RTL and testbench
=======================================

// Module: bin_decode_scheduler
// PURPOSE
//  Sequences the arithmetic Decoder from a stream of decode commands {pState, bypass, numBins}.
//  Issues per-cycle n_bin: 1 bin/cycle in regular mode, up to BIN_WIDTH bins/cycle in bypass mode.
//  Counts the decoded bins and returns them through a one-entry valid/ready output register.
//  Sits between the command source (parsed stream) and Decoder; the byte FileReader feeds Decoder directly.
// PARAMETERS
//  BIN_WIDTH  4  max bins per decoder step (bypass); also the width of dec_bin and bin_data
//  NB_W       7  width of the numBins field
// PORTS
//  clk           in   1          clock; all logic on posedge
//  reset         in   1          asynchronous, active-low reset
//  cmd_valid     in   1          command available
//  cmd_ready     out  1          command accepted when cmd_valid&&cmd_ready at posedge
//  cmd_pstate    in   8          context state for the command
//  cmd_bypass    in   1          1 = bypass bins, 0 = regular (context) bins
//  cmd_num_bins  in   NB_W       bins to decode (0 allowed)
//  dec_en        out  1          Decoder advances one step this cycle
//  dec_bypass    out  1          to Decoder .bypass
//  dec_pstate    out  8          to Decoder .pState_in
//  dec_n_bin     out  clog2(BIN_WIDTH)  to Decoder .n_bin (= bins this step - 1)
//  dec_stall     in   1          Decoder waiting for a byte; do not advance
//  dec_bin       in   BIN_WIDTH  Decoder bins, valid in the dec_en cycle; LSB = first bin
//  bin_valid     out  1          bin_data holds bins
//  bin_ready     in   1          consumer takes bin_data
//  bin_data      out  BIN_WIDTH  captured bins; bits above bin_cnt-1 are 0
//  bin_cnt       out  clog2(BIN_WIDTH)+1  number of valid bits in bin_data (1..BIN_WIDTH)
//  bin_last      out  1          bin_data holds the final bins of the command
//  cmd_done      out  1          one-cycle pulse: command fully issued
//  busy          out  1          state != IDLE
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; cmd_ready=1; dec_en=0, dec_bypass=0, dec_pstate=0, dec_n_bin=0;
//    bin_valid=0, bin_data=0, bin_cnt=0, bin_last=0, cmd_done=0; remaining=0. Pending bins are dropped.
//  FSM IDLE: cmd_ready=1. On accept, latch pstate/bypass; remaining=num_bins.
//    If num_bins==0 -> stay IDLE, cmd_done=1 next cycle, no dec_en and no bin_valid. Otherwise -> RUN.
//  FSM RUN: cmd_ready=0; step = bypass ? min(remaining,BIN_WIDTH) : 1; dec_n_bin = step-1 (combinational).
//    dec_en = RUN && !dec_stall && (!bin_valid || bin_ready).
//    On a dec_en edge: bin_data=dec_bin masked to step bits, bin_cnt=step, bin_valid=1, remaining-=step.
//    When step==remaining: bin_last=1, cmd_done=1 on the same edge, -> IDLE.
//  Output register: bin_valid clears on bin_valid&&bin_ready unless reloaded on the same edge.
//    Holds under backpressure; the Decoder never advances while bin_valid && !bin_ready.
//  Latency: accept edge -> first dec_en possible in the next cycle -> bin_valid 1 cycle after dec_en.
//    Back-to-back commands: IDLE costs one cycle between commands.
//  Steady state (no stall, bin_ready=1): one step per cycle; a regular command of N bins takes N cycles.
//  Arithmetic: remaining is NB_W bits and never underflows (step<=remaining).
//    Non-final bypass steps always carry BIN_WIDTH bins.
//  dec_pstate/dec_bypass are held from the latched command for the whole RUN; in IDLE they keep their last value.
//  dec_stall and backpressure in the same cycle: no advance, no state change.
//  Reset in RUN: immediately IDLE; the partially decoded command is abandoned and not signalled done.
// CONFIGURATION
//  SCHED_PERF_CNT_EN defined: adds outputs perf_bins[31:0] and perf_stall[31:0].
//    perf_bins: bins issued, +step per dec_en.
//    perf_stall: cycles in RUN with dec_en=0.
//    Both saturate at 32'hFFFFFFFF and clear on reset.
//  SCHED_PERF_CNT_EN undefined: ports and counters are absent; behaviour is otherwise identical.
// TESTING
//  Regular cmd {pstate=8'h3A, bypass=0, n=5}, bin_ready=1 -> 5 dec_en cycles, dec_n_bin=0, dec_pstate=3A;
//    bin_cnt=1 each; bin_last+cmd_done on the 5th.
//  Bypass n=10, BIN_WIDTH=4 -> steps 4,4,2; dec_n_bin=3,3,1; last bin_data bits[3:2]=0.
//  n=0 cmd -> no dec_en, cmd_done pulse 1 cycle after accept; a following cmd n=1 is accepted the next cycle.
//  Bypass n=8, bin_ready held 0 for 3 cycles after the first bin_valid -> dec_en=0 during the hold;
//    bin_data stable; no bins lost.
//  dec_stall=1 for 4 cycles mid-command -> dec_en=0, remaining unchanged; perf_stall+=4 if SCHED_PERF_CNT_EN.
//  reset=0 while RUN with remaining=6 -> all outputs at reset values asynchronously, no cmd_done;
//    a new cmd is accepted after release.

Source files
------------

// File: rtl/bin_decode_scheduler.sv
// Issues Decoder steps from {pState,bypass,numBins} commands: 1 bin/step regular, up to BIN_WIDTH bypass; bins 1 cycle after dec_en.
// Decoder held off under dec_stall or output backpressure; optional SCHED_PERF_CNT_EN adds perf_bins/perf_stall counters.
module bin_decode_scheduler #(
  parameter int BIN_WIDTH = 4,
  parameter int NB_W      = 7
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [7:0]                     cmd_pstate,
  input  logic                           cmd_bypass,
  input  logic [NB_W-1:0]                cmd_num_bins,
  output logic                           dec_en,
  output logic                           dec_bypass,
  output logic [7:0]                     dec_pstate,
  output logic [$clog2(BIN_WIDTH)-1:0]   dec_n_bin,
  input  logic                           dec_stall,
  input  logic [BIN_WIDTH-1:0]           dec_bin,
  output logic                           bin_valid,
  input  logic                           bin_ready,
  output logic [BIN_WIDTH-1:0]           bin_data,
  output logic [$clog2(BIN_WIDTH):0]     bin_cnt,
  output logic                           bin_last,
  output logic                           cmd_done,
  output logic                           busy
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]                    perf_bins,
  output logic [31:0]                    perf_stall
`endif
);

  localparam int NBIN_W = $clog2(BIN_WIDTH);
  localparam int CNT_W  = $clog2(BIN_WIDTH) + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                r_state, w_state_nxt;
  logic [7:0]            r_pstate;
  logic                  r_bypass;
  logic [NB_W-1:0]       r_remaining;
  logic [BIN_WIDTH-1:0]  r_bin_data;
  logic [CNT_W-1:0]      r_bin_cnt;
  logic                  r_bin_valid;
  logic                  r_bin_last;
  logic                  r_cmd_done;
  logic [NB_W-1:0]       w_step;
  logic [BIN_WIDTH-1:0]  w_mask;
  logic                  w_accept;
  logic                  w_final;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step      = NB_W'(1);
    w_mask      = '0;
    w_accept    = 1'b0;
    cmd_ready   = 1'b0;
    dec_en      = 1'b0;
    // Step size only matters in RUN; outside it dec_n_bin idles at 0.
    if (r_state == S_RUN && r_bypass) begin
      if (r_remaining > NB_W'(BIN_WIDTH)) w_step = NB_W'(BIN_WIDTH);
      else                                w_step = r_remaining;
    end
    for (int i = 0; i < BIN_WIDTH; i++) w_mask[i] = (NB_W'(i) < w_step);
    w_final = (w_step == r_remaining);
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        w_accept  = cmd_valid;
        if (cmd_valid && (cmd_num_bins != '0)) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        dec_en = !dec_stall && (!r_bin_valid || bin_ready);
        if (dec_en && w_final) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pstate    <= '0;
      r_bypass    <= 1'b0;
      r_remaining <= '0;
      r_bin_data  <= '0;
      r_bin_cnt   <= '0;
      r_bin_valid <= 1'b0;
      r_bin_last  <= 1'b0;
      r_cmd_done  <= 1'b0;
    end else begin
      r_cmd_done <= 1'b0;
      if (w_accept) begin
        r_pstate    <= cmd_pstate;
        r_bypass    <= cmd_bypass;
        r_remaining <= cmd_num_bins;
        r_cmd_done  <= (cmd_num_bins == '0);
      end
      if (dec_en) begin
        r_remaining <= r_remaining - w_step;
        r_bin_data  <= dec_bin & w_mask;
        r_bin_cnt   <= CNT_W'(w_step);
        r_bin_valid <= 1'b1;
        r_bin_last  <= w_final;
        r_cmd_done  <= w_final;
      end else if (r_bin_valid && bin_ready) begin
        r_bin_valid <= 1'b0;
      end
    end
  end

  assign dec_bypass = r_bypass;
  assign dec_pstate = r_pstate;
  assign dec_n_bin  = NBIN_W'(w_step - NB_W'(1));
  assign bin_valid  = r_bin_valid;
  assign bin_data   = r_bin_data;
  assign bin_cnt    = r_bin_cnt;
  assign bin_last   = r_bin_last;
  assign cmd_done   = r_cmd_done;
  assign busy       = (r_state != S_IDLE);

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] r_perf_bins;
  logic [31:0] r_perf_stall;
  logic [32:0] w_bins_sum;

  assign w_bins_sum = {1'b0, r_perf_bins} + 33'(w_step);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_bins  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (dec_en) r_perf_bins <= w_bins_sum[32] ? 32'hFFFF_FFFF : w_bins_sum[31:0];
      if (r_state == S_RUN && !dec_en && r_perf_stall != 32'hFFFF_FFFF)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_bins  = r_perf_bins;
  assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_bin_decode_scheduler.sv
// Bench for bin_decode_scheduler: table of commands plus hand sequences for backpressure, stall and reset-in-RUN.
module tb_bin_decode_scheduler;

  logic       clk, reset;
  logic       cmd_valid, cmd_ready, cmd_bypass;
  logic [7:0] cmd_pstate;
  logic [6:0] cmd_num_bins;
  logic       dec_en, dec_bypass, dec_stall;
  logic [7:0] dec_pstate;
  logic [1:0] dec_n_bin;
  logic [3:0] dec_bin;
  logic       bin_valid, bin_ready, bin_last, cmd_done, busy;
  logic [3:0] bin_data;
  logic [2:0] bin_cnt;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_bins, perf_stall;
`endif

  bin_decode_scheduler #(.BIN_WIDTH(4), .NB_W(7)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pstate(cmd_pstate),
    .cmd_bypass(cmd_bypass), .cmd_num_bins(cmd_num_bins),
    .dec_en(dec_en), .dec_bypass(dec_bypass), .dec_pstate(dec_pstate),
    .dec_n_bin(dec_n_bin), .dec_stall(dec_stall), .dec_bin(dec_bin),
    .bin_valid(bin_valid), .bin_ready(bin_ready), .bin_data(bin_data),
    .bin_cnt(bin_cnt), .bin_last(bin_last), .cmd_done(cmd_done), .busy(busy)
`ifdef SCHED_PERF_CNT_EN
    , .perf_bins(perf_bins), .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic [2:0] cnt;
    logic       last;
  } bin_t;

  typedef struct {
    logic [7:0] pstate;
    logic       byp;
    int         n;
    int         exp_steps;
  } vec_t;

  bin_t q_bin[$];
  int   q_nbin[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] exp_pstate = 8'h00;
  logic       exp_bypass = 1'b0;
  int   tb_cmd_id = 0;
  int   dec_id = 0;
  int   k_obs = 0;

  // Decoder stand-in: upper bits always set so masking errors show up.
  function automatic logic [3:0] pat(input int id, input int k);
    logic [1:0] lo;
    lo  = 2'(id + k);
    pat = {2'b11, lo};
  endfunction

  assign dec_bin = pat(dec_id, k_obs);

  always @(posedge clk or negedge reset) begin
    if (!reset) k_obs <= 0;
    else if (cmd_valid && cmd_ready) begin
      k_obs  <= 0;
      dec_id <= tb_cmd_id;
    end else if (dec_en) k_obs <= k_obs + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int id, input logic byp, input int n);
    int   rem;
    int   k;
    int   st;
    bin_t b;
    rem = n;
    k   = 0;
    while (rem > 0) begin
      st     = byp ? ((rem > 4) ? 4 : rem) : 1;
      b.data = pat(id, k) & 4'((1 << st) - 1);
      b.cnt  = 3'(st);
      b.last = (st == rem);
      q_bin.push_back(b);
      q_nbin.push_back(st - 1);
      rem -= st;
      k++;
    end
  endtask

  bin_t m_b;
  int   m_e;
  always @(negedge clk) begin
    if (reset) begin
      if (dec_en) begin
        if (q_nbin.size() == 0) chk("dec_en_unexpected", {31'b0, dec_en}, 32'd0);
        else begin
          m_e = q_nbin.pop_front();
          chk("dec_n_bin", {30'b0, dec_n_bin}, m_e);
          chk("dec_pstate", {24'b0, dec_pstate}, {24'b0, exp_pstate});
          chk("dec_bypass", {31'b0, dec_bypass}, {31'b0, exp_bypass});
        end
      end
      if (bin_valid && bin_ready) begin
        if (q_bin.size() == 0) chk("bin_unexpected", {31'b0, bin_valid}, 32'd0);
        else begin
          m_b = q_bin.pop_front();
          chk("bin_data", {28'b0, bin_data}, {28'b0, m_b.data});
          chk("bin_cnt", {29'b0, bin_cnt}, {29'b0, m_b.cnt});
          chk("bin_last", {31'b0, bin_last}, {31'b0, m_b.last});
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int id, input logic [7:0] ps, input logic byp, input int n);
    chk("cmd_ready_at_issue", {31'b0, cmd_ready}, 32'd1);
    push_exp(id, byp, n);
    exp_pstate   = ps;
    exp_bypass   = byp;
    tb_cmd_id    = id;
    cmd_pstate   = ps;
    cmd_bypass   = byp;
    cmd_num_bins = 7'(n);
    cmd_valid    = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int ens);
    int got;
    got = 0;
    cyc = 0;
    ens = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cyc++;
      if (dec_en) ens++;
      if (cmd_done) begin
        got = 1;
        break;
      end
    end
    chk("cmd_done_seen", got, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bin_valid) break;
    end
    chk("bins_outstanding", q_bin.size(), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
    chk({tag, "_dec_en"}, {31'b0, dec_en}, 32'd0);
    chk({tag, "_dec_bypass"}, {31'b0, dec_bypass}, 32'd0);
    chk({tag, "_dec_pstate"}, {24'b0, dec_pstate}, 32'd0);
    chk({tag, "_dec_n_bin"}, {30'b0, dec_n_bin}, 32'd0);
    chk({tag, "_bin_valid"}, {31'b0, bin_valid}, 32'd0);
    chk({tag, "_bin_data"}, {28'b0, bin_data}, 32'd0);
    chk({tag, "_bin_cnt"}, {29'b0, bin_cnt}, 32'd0);
    chk({tag, "_bin_last"}, {31'b0, bin_last}, 32'd0);
    chk({tag, "_cmd_done"}, {31'b0, cmd_done}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t vt[7];
  int   cyc, ens, seen;

  initial begin
    vt[0] = '{pstate: 8'h3A, byp: 1'b0, n: 5,  exp_steps: 5};
    vt[1] = '{pstate: 8'h55, byp: 1'b1, n: 10, exp_steps: 3};
    vt[2] = '{pstate: 8'h11, byp: 1'b1, n: 8,  exp_steps: 2};
    vt[3] = '{pstate: 8'h22, byp: 1'b1, n: 3,  exp_steps: 1};
    vt[4] = '{pstate: 8'h7F, byp: 1'b0, n: 1,  exp_steps: 1};
    vt[5] = '{pstate: 8'h44, byp: 1'b1, n: 4,  exp_steps: 1};
    vt[6] = '{pstate: 8'h66, byp: 1'b1, n: 0,  exp_steps: 0};

    reset = 1'b0; cmd_valid = 1'b0; cmd_pstate = '0; cmd_bypass = 1'b0;
    cmd_num_bins = '0; dec_stall = 1'b0; bin_ready = 1'b1;
    #12 chk_reset("por");
    sync();
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      sync();
      issue(i + 1, vt[i].pstate, vt[i].byp, vt[i].n);
      wait_done(cyc, ens);
      chk("vec_steps", ens, vt[i].exp_steps);
      chk("vec_latency", cyc, vt[i].exp_steps + 1);
      drain();
    end

    // n=0 followed by n=1 on the very next cycle
    sync();
    chk("b2b_ready", {31'b0, cmd_ready}, 32'd1);
    tb_cmd_id = 19; cmd_pstate = 8'h5C; cmd_bypass = 1'b0; cmd_num_bins = 7'd0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    push_exp(20, 1'b0, 1);
    exp_pstate = 8'h9D; exp_bypass = 1'b0; tb_cmd_id = 20;
    cmd_pstate = 8'h9D; cmd_num_bins = 7'd1;
    @(negedge clk);
    chk("zero_done_pulse", {31'b0, cmd_done}, 32'd1);
    chk("zero_no_dec_en", {31'b0, dec_en}, 32'd0);
    chk("zero_no_bin", {31'b0, bin_valid}, 32'd0);
    chk("zero_still_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_done(cyc, ens);
    chk("b2b_steps", ens, 1);
    chk("b2b_latency", cyc, 2);
    drain();

    // output backpressure on bypass n=8
    sync();
    bin_ready = 1'b0;
    issue(30, 8'hA5, 1'b1, 8);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bin_valid) begin
        seen = 1;
        break;
      end
    end
    chk("bp_first_valid", seen, 1);
    for (int h = 0; h < 3; h++) begin
      chk("bp_hold_dec_en", {31'b0, dec_en}, 32'd0);
      chk("bp_hold_data", {28'b0, bin_data}, {28'b0, pat(30, 0)});
      chk("bp_hold_valid", {31'b0, bin_valid}, 32'd1);
      if (h < 2) @(negedge clk);
    end
    sync();
    bin_ready = 1'b1;
    wait_done(cyc, ens);
    chk("bp_rest_steps", ens, 1);
    drain();

    // decoder stall for 4 cycles mid-command, from a fresh reset
    sync();
    reset = 1'b0;
    sync();
    reset = 1'b1;
    issue(40, 8'h12, 1'b0, 6);
    seen = 0;
    for (int i = 0; i < 20 && seen < 2; i++) begin
      @(negedge clk);
      if (dec_en) seen++;
    end
    chk("stall_pre_steps", seen, 2);
    sync();
    dec_stall = 1'b1;
    for (int h = 0; h < 4; h++) begin
      @(negedge clk);
      chk("stall_dec_en", {31'b0, dec_en}, 32'd0);
      chk("stall_busy", {31'b0, busy}, 32'd1);
    end
    sync();
    dec_stall = 1'b0;
    wait_done(cyc, ens);
    chk("stall_post_steps", ens, 4);
`ifdef SCHED_PERF_CNT_EN
    chk("perf_stall", perf_stall, 32'd4);
    chk("perf_bins", perf_bins, 32'd6);
`endif
    drain();

    // reset while RUN with 6 bins remaining
    sync();
    issue(50, 8'hC3, 1'b0, 10);
    seen = 0;
    for (int i = 0; i < 20 && seen < 4; i++) begin
      @(negedge clk);
      if (dec_en) seen++;
    end
    chk("rst_pre_steps", seen, 4);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_reset("rst_run");
    q_bin.delete();
    q_nbin.delete();
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      chk("rst_hold_done", {31'b0, cmd_done}, 32'd0);
    end
    sync();
    reset = 1'b1;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      chk("rst_after_done", {31'b0, cmd_done}, 32'd0);
      chk("rst_after_busy", {31'b0, busy}, 32'd0);
    end
    sync();
    issue(51, 8'h0F, 1'b0, 2);
    wait_done(cyc, ens);
    chk("rst_new_steps", ens, 2);
    chk("rst_new_latency", cyc, 3);
    drain();

    chk("final_nbin_queue", q_nbin.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
